// File: rtl/pipe_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32 pipe: load-use stalls,
// mispredict flushes, MMIO freeze and IMEM-store refetch.
module pipe_ctrl #(
  parameter int unsigned IO_TIMEOUT = 255,
  parameter int unsigned IMEM_LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_br_mispred,
  input  logic        id_target_taken,
  input  logic        mem_imem_wr,
  input  logic [31:0] mem_pc,
  input  logic        mem_io_req,
  input  logic        mem_io_ready,
  output logic        stall_if,
  output logic        stall_id,
  output logic        bubble_ex,
  output logic        stall_all,
  output logic        flush_if,
  output logic        flush_id,
  output logic        flush_ex,
  output logic        refetch_en,
  output logic [31:0] refetch_pc,
  output logic        io_timeout,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, IO_WAIT, IMEM_HOLD} state_e;

  state_e      state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic [2:0]  hold_q, hold_d;
  logic [31:0] refetch_pc_q, refetch_pc_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic hz, io_block;
  logic stall_if_c, stall_id_c, bubble_ex_c, stall_all_c;
  logic flush_if_c, flush_id_c, flush_ex_c, refetch_en_c, io_timeout_c;

  assign hz = id_valid & ex_valid & ex_is_load & (ex_rd != 5'd0) &
              ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
  assign io_block = mem_io_req & ~mem_io_ready;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    hold_d       = hold_q;
    refetch_pc_d = refetch_pc_q;
    stall_if_c   = 1'b0;
    stall_id_c   = 1'b0;
    bubble_ex_c  = 1'b0;
    stall_all_c  = 1'b0;
    flush_if_c   = 1'b0;
    flush_id_c   = 1'b0;
    flush_ex_c   = 1'b0;
    refetch_en_c = 1'b0;
    io_timeout_c = 1'b0;
    case (state_q)
      RUN: begin
        flush_if_c = ex_br_mispred | (id_target_taken & ~hz);
        flush_id_c = ex_br_mispred;
        if (io_block) begin
          stall_all_c = 1'b1;
          timer_d     = 8'd1;
          state_d     = IO_WAIT;
        end else if (mem_imem_wr) begin
          flush_if_c   = 1'b1;
          flush_id_c   = 1'b1;
          flush_ex_c   = 1'b1;
          refetch_pc_d = mem_pc + 32'd4;
          hold_d       = IMEM_LAT[2:0];
          state_d      = IMEM_HOLD;
        end
        // A flush of the younger stages makes the load-use stall moot.
        if (hz & ~ex_br_mispred & ~(mem_imem_wr & ~io_block)) begin
          stall_if_c  = 1'b1;
          stall_id_c  = 1'b1;
          bubble_ex_c = 1'b1;
        end
      end
      IO_WAIT: begin
        if (mem_io_ready) begin
          state_d = RUN;
        end else if (timer_q == IO_TIMEOUT[7:0]) begin
          io_timeout_c = 1'b1;
          state_d      = RUN;
        end else begin
          stall_all_c = 1'b1;
          timer_d     = timer_q + 8'd1;
        end
      end
      IMEM_HOLD: begin
        bubble_ex_c = 1'b1;
        hold_d      = hold_q - 3'd1;
        if (hold_q == 3'd1) begin
          refetch_en_c = 1'b1;
          state_d      = RUN;
        end else begin
          stall_if_c = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
    stall_cnt_d = stall_cnt_q + {31'd0, stall_if_c | stall_all_c};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RUN;
      timer_q      <= 8'd0;
      hold_q       <= 3'd0;
      refetch_pc_q <= 32'd0;
      stall_cnt_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      hold_q       <= hold_d;
      refetch_pc_q <= refetch_pc_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  // Combinational controls are masked so reset forces every output low at once.
  assign stall_if   = rst & stall_if_c;
  assign stall_id   = rst & stall_id_c;
  assign bubble_ex  = rst & bubble_ex_c;
  assign stall_all  = rst & stall_all_c;
  assign flush_if   = rst & flush_if_c;
  assign flush_id   = rst & flush_id_c;
  assign flush_ex   = rst & flush_ex_c;
  assign refetch_en = rst & refetch_en_c;
  assign io_timeout = rst & io_timeout_c;
  assign refetch_pc = refetch_pc_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: behavioural model checked every cycle plus
// hand-computed literal checks per scenario.
module tb_pipe_ctrl;
  localparam int TO  = 8;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_valid, id_uses_rs1, id_uses_rs2, ex_valid, ex_is_load;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        ex_br_mispred, id_target_taken, mem_imem_wr, mem_io_req, mem_io_ready;
  logic [31:0] mem_pc;
  logic        stall_if, stall_id, bubble_ex, stall_all, flush_if, flush_id, flush_ex;
  logic        refetch_en, io_timeout;
  logic [31:0] refetch_pc, stall_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.IO_TIMEOUT(TO), .IMEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .ex_br_mispred(ex_br_mispred), .id_target_taken(id_target_taken),
    .mem_imem_wr(mem_imem_wr), .mem_pc(mem_pc),
    .mem_io_req(mem_io_req), .mem_io_ready(mem_io_ready),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .stall_all(stall_all), .flush_if(flush_if), .flush_id(flush_id),
    .flush_ex(flush_ex), .refetch_en(refetch_en), .refetch_pc(refetch_pc),
    .io_timeout(io_timeout), .stall_cnt(stall_cnt)
  );

  // Model: mode 0 = running, 1 = waiting on MMIO, 2 = holding fetch after IMEM store
  int          m_mode, m_waited, m_left;
  logic [31:0] m_rpc, m_cnt, cnt_bias;
  logic        e_sif, e_sid, e_bex, e_sall, e_fif, e_fid, e_fex, e_ref, e_to;
  logic        lu, io_blk, reads_rd;

  always_comb begin
    e_sif = 0; e_sid = 0; e_bex = 0; e_sall = 0;
    e_fif = 0; e_fid = 0; e_fex = 0; e_ref = 0; e_to = 0;
    reads_rd = (id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd);
    lu       = id_valid && ex_valid && ex_is_load && ex_rd != 0 && reads_rd;
    io_blk   = mem_io_req && !mem_io_ready;
    if (rst) begin
      if (m_mode == 0) begin
        e_fif  = ex_br_mispred || (id_target_taken && !lu) || (mem_imem_wr && !io_blk);
        e_fid  = ex_br_mispred || (mem_imem_wr && !io_blk);
        e_fex  = mem_imem_wr && !io_blk;
        e_sall = io_blk;
        e_sif  = lu && !ex_br_mispred && !e_fex;
        e_sid  = e_sif;
        e_bex  = e_sif;
      end else if (m_mode == 1) begin
        e_to   = !mem_io_ready && m_waited == TO;
        e_sall = !mem_io_ready && m_waited != TO;
      end else begin
        e_bex = 1;
        e_ref = m_left == 1;
        e_sif = m_left != 1;
      end
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode <= 0; m_waited <= 0; m_left <= 0; m_rpc <= 0; m_cnt <= 0;
    end else begin
      m_cnt <= m_cnt + ((e_sif || e_sall) ? 32'd1 : 32'd0);
      if (m_mode == 0) begin
        if (io_blk) begin m_mode <= 1; m_waited <= 1; end
        else if (mem_imem_wr) begin m_mode <= 2; m_left <= LAT; m_rpc <= mem_pc + 32'd4; end
      end else if (m_mode == 1) begin
        if (mem_io_ready || m_waited == TO) m_mode <= 0;
        else m_waited <= m_waited + 1;
      end else begin
        if (m_left == 1) m_mode <= 0;
        m_left <= m_left - 1;
      end
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cmp("m.stall_if",   {31'd0, stall_if},   {31'd0, e_sif});
    cmp("m.stall_id",   {31'd0, stall_id},   {31'd0, e_sid});
    cmp("m.bubble_ex",  {31'd0, bubble_ex},  {31'd0, e_bex});
    cmp("m.stall_all",  {31'd0, stall_all},  {31'd0, e_sall});
    cmp("m.flush_if",   {31'd0, flush_if},   {31'd0, e_fif});
    cmp("m.flush_id",   {31'd0, flush_id},   {31'd0, e_fid});
    cmp("m.flush_ex",   {31'd0, flush_ex},   {31'd0, e_fex});
    cmp("m.refetch_en", {31'd0, refetch_en}, {31'd0, e_ref});
    cmp("m.io_timeout", {31'd0, io_timeout}, {31'd0, e_to});
    cmp("m.refetch_pc", refetch_pc, m_rpc);
    cmp("m.stall_cnt",  stall_cnt, m_cnt + cnt_bias);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_valid = 0; ex_rd = 0; ex_is_load = 0; ex_br_mispred = 0; id_target_taken = 0;
    mem_imem_wr = 0; mem_pc = 0; mem_io_req = 0; mem_io_ready = 0;
  endtask

  // EX: lw x<rd>; ID: add x6, x<rs1>, x1
  task automatic load_use(input logic [4:0] rd, input logic [4:0] rs1);
    ex_valid = 1; ex_is_load = 1; ex_rd = rd;
    id_valid = 1; id_rs1 = rs1; id_rs2 = 5'd1; id_uses_rs1 = 1; id_uses_rs2 = 1;
  endtask

  initial begin
    cnt_bias = 0;
    idle();
    // Reset held with a blocking MMIO access and a hazard present
    mem_io_req = 1; load_use(5'd5, 5'd5);
    #12;
    cmp("rst.stall_all", {31'd0, stall_all}, 32'd0);
    cmp("rst.stall_if",  {31'd0, stall_if},  32'd0);
    cmp("rst.stall_cnt", stall_cnt, 32'd0);
    cmp("rst.refetch_pc", refetch_pc, 32'd0);
    idle();
    tick(); rst = 1;

    // Load-use: one stall cycle, then resolved
    tick(); load_use(5'd5, 5'd5); #2;
    cmp("lu.stall_if",  {31'd0, stall_if},  32'd1);
    cmp("lu.stall_id",  {31'd0, stall_id},  32'd1);
    cmp("lu.bubble_ex", {31'd0, bubble_ex}, 32'd1);
    tick(); ex_is_load = 0; ex_rd = 5'd6; id_rs1 = 5'd7; #2;
    cmp("lu.after", {31'd0, stall_if}, 32'd0);
    cmp("lu.cnt", stall_cnt, 32'd1);
    tick(); load_use(5'd0, 5'd0); #2;
    cmp("lu.x0", {31'd0, stall_if}, 32'd0);

    // Mispredict overrides load-use
    tick(); load_use(5'd5, 5'd5); ex_br_mispred = 1; #2;
    cmp("mp.flush_if",  {31'd0, flush_if},  32'd1);
    cmp("mp.flush_id",  {31'd0, flush_id},  32'd1);
    cmp("mp.stall_if",  {31'd0, stall_if},  32'd0);
    cmp("mp.bubble_ex", {31'd0, bubble_ex}, 32'd0);
    tick(); idle(); #2;
    cmp("mp.cnt", stall_cnt, 32'd1);
    // Taken jump in ID under a load-use stall: no flush
    tick(); load_use(5'd9, 5'd9); id_target_taken = 1; #2;
    cmp("tt.hz.flush_if", {31'd0, flush_if}, 32'd0);
    cmp("tt.hz.stall_if", {31'd0, stall_if}, 32'd1);
    tick(); idle(); id_target_taken = 1; #2;
    cmp("tt.flush_if", {31'd0, flush_if}, 32'd1);
    cmp("tt.flush_id", {31'd0, flush_id}, 32'd0);

    // MMIO ready on the 5th cycle: 4 stall cycles
    tick(); idle(); mem_io_req = 1;
    for (int i = 0; i < 4; i++) begin
      #2 cmp("io.stall", {31'd0, stall_all}, 32'd1);
      tick();
      if (i == 1) begin ex_br_mispred = 1; load_use(5'd5, 5'd5); end
    end
    idle(); mem_io_req = 1; mem_io_ready = 1; #2;
    cmp("io.ready", {31'd0, stall_all}, 32'd0);
    tick(); idle(); #2;
    cmp("io.run", {31'd0, stall_all}, 32'd0);
    cmp("io.cnt", stall_cnt, 32'd6);

    // MMIO timeout: 8 stall cycles, pulse on the 9th
    tick(); mem_io_req = 1;
    for (int i = 0; i <= TO; i++) begin
      #2;
      cmp("to.stall", {31'd0, stall_all}, (i == TO) ? 32'd0 : 32'd1);
      cmp("to.pulse", {31'd0, io_timeout}, (i == TO) ? 32'd1 : 32'd0);
      tick();
    end
    idle(); #2;
    cmp("to.after", {31'd0, io_timeout | stall_all}, 32'd0);
    cmp("to.cnt", stall_cnt, 32'd14);

    // IMEM store
    tick(); mem_imem_wr = 1; mem_pc = 32'h1000_0FFC; #2;
    cmp("im.flush", {29'd0, flush_if, flush_id, flush_ex}, 32'd7);
    tick(); idle(); ex_br_mispred = 1; #2;
    cmp("im.hold.stall_if", {31'd0, stall_if}, 32'd1);
    cmp("im.hold.mispred",  {31'd0, flush_if}, 32'd0);
    cmp("im.hold.ref",      {31'd0, refetch_en}, 32'd0);
    cmp("im.refetch_pc", refetch_pc, 32'h1000_1000);
    tick(); idle(); #2;
    cmp("im.ref", {31'd0, refetch_en}, 32'd1);
    cmp("im.ref.stall_if", {31'd0, stall_if}, 32'd0);
    tick(); #2;
    cmp("im.done", {31'd0, refetch_en}, 32'd0);
    tick(); mem_imem_wr = 1; mem_pc = 32'hFFFF_FFFC;
    tick(); idle(); #2;
    cmp("im.wrap", refetch_pc, 32'd0);
    tick(); tick();
    // IMEM store colliding with blocking MMIO: MMIO wins
    mem_imem_wr = 1; mem_pc = 32'h2000; mem_io_req = 1; #2;
    cmp("im.io.flush_ex", {31'd0, flush_ex}, 32'd0);
    cmp("im.io.stall_all", {31'd0, stall_all}, 32'd1);
    tick(); idle(); mem_io_ready = 1;
    tick(); idle(); #2;
    cmp("im.io.pc", refetch_pc, 32'd0);

    // Reset on the 3rd MMIO stall cycle
    tick(); mem_io_req = 1;
    tick(); tick(); #2;
    rst = 0; #1;
    cmp("ar.stall_all", {31'd0, stall_all}, 32'd0);
    cmp("ar.cnt", stall_cnt, 32'd0);
    cmp("ar.pc", refetch_pc, 32'd0);
    idle();
    tick(); rst = 1;
    tick(); #2;
    cmp("ar.run", {31'd0, stall_all | stall_if}, 32'd0);
    cmp("ar.cnt2", stall_cnt, 32'd0);

    // Counter wrap
    tick();
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    cnt_bias = 32'hFFFF_FFFF - m_cnt;
    #1 release dut.stall_cnt_q;
    #1 cmp("wrap.pre", stall_cnt, 32'hFFFF_FFFF);
    tick(); load_use(5'd3, 5'd3);
    tick(); idle(); #2;
    cmp("wrap.post", stall_cnt, 32'd0);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
